addsub_seq: RTL and testbench
=============================

Name: addsub_seq

Overview:
- Parametrised, multi-cycle successor to the team's combinational 6-bit adder/subtractor.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock using a registered inter-chunk carry.
- Provides a start/busy/done handshake plus carry, signed-overflow and zero flags.
- Used where a full-width carry chain would not meet timing, or where area matters more than latency.

Parameters:
WIDTH, 6, operand/result width in bits; must be >= 1.
CHUNK, 2, bits processed per cycle; 1 <= CHUNK <= WIDTH and WIDTH % CHUNK == 0 (elaboration-time check, $error on violation).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only on edges where busy is 0.
sub  input  1  0 = A+B, 1 = A-B; captured with start.
a  input  WIDTH  operand A; captured with start.
b  input  WIDTH  operand B; captured with start.
busy  output  1  operation in progress.
done  output  1  one-cycle pulse; result and flags valid from this cycle.
result  output  WIDTH  sum/difference, modulo 2^WIDTH.
carry_out  output  1  add: carry out of MSB; sub: 1 = no borrow (A >= B unsigned).
overflow  output  1  two's-complement signed overflow.
zero  output  1  result == 0.

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n=0, asynchronous): state=IDLE; busy, done, result, carry_out, overflow, zero, chunk counter and internal operand/carry registers all 0. An in-flight operation is aborted with no done pulse. First start is accepted on the first edge after rst_n rises.
- Let N = WIDTH/CHUNK.
- IDLE:
  - Edge E0 with start=1 and busy=0: latch a, b XOR {WIDTH{sub}}, carry register = sub, sub flag; counter = 0; go to RUN; busy=1.
  - start=0: stay in IDLE.
- RUN:
  - Edges E1..EN each add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) of the latched operands plus the carry register.
  - Each chunk sum is written to the matching result slice; the carry register and counter are updated.
  - Intermediate result slices are not guaranteed visible; only values at done are defined.
- Completion at EN:
  - busy=0, done=1.
  - carry_out = final carry.
  - overflow = (A[MSB] == B'[MSB]) && (result[MSB] != A[MSB]), where B' is the inverted operand on sub.
  - zero = (result == 0).
  - Latency is N edges after the accepting edge; for CHUNK=WIDTH, done rises at E1.
- done is high for exactly one cycle. result and flags hold until the next completion; they are not cleared by a new start.
- start while busy=1 is ignored and not queued; a, b and sub changes during RUN have no effect.
- Back-to-back: start=1 on the edge after EN (busy=0) is accepted; done falls on that same edge. Maximum throughput is one operation per N+1 cycles.
- Arithmetic is purely modulo 2^WIDTH, with no saturation.
- Subtract uses A + ~B + 1, with the +1 injected as the initial carry.

Test Plan:
- Subtract, no borrow: WIDTH=6, CHUNK=2, sub=1, a=45, b=7, start pulse at E0 -> busy=1 E0..E2; done=1 only after E3; result=6'b100110 (38), carry_out=1, overflow=0, zero=0.
- Add and overflow cases, WIDTH=6, CHUNK=2:
  - sub=0, a=45, b=7 -> result=52 (6'b110100), carry_out=0, overflow=0.
  - a=31, b=1 -> result=32, overflow=1, carry_out=0.
  - a=63, b=1 -> result=0, carry_out=1, zero=1, overflow=0.
- Borrow and zero, sub=1:
  - a=7, b=45 -> result=26 (6'b011010), carry_out=0, overflow=0.
  - a=20, b=20 -> result=0, zero=1, carry_out=1.
- Handshake:
  - start held high through RUN with a/b/sub changed mid-operation -> single done pulse with the original operation's result.
  - Start on the edge after done -> accepted; second done exactly N+1 cycles after the first.
- Reset mid-operation: assert rst_n=0 asynchronously one cycle after E0 -> all outputs 0 immediately with no later done pulse. After release, sub=1, a=45, b=7 completes normally with result 38.
- Parameter sweep: CHUNK in {1,2,3,6} for WIDTH=6, and WIDTH=16 with CHUNK in {1,4,16}; random a/b/sub -> result, carry_out, overflow and zero match a reference model, with latency exactly N.

Source files
------------

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock through a
// registered inter-chunk carry, with a start/busy/done handshake and
// carry, signed-overflow and zero flags valid from the done cycle.
module addsub_seq #(
  parameter int WIDTH = 6,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("addsub_seq: illegal WIDTH/CHUNK combination");
  end

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               done_q, done_d;
  logic               carry_out_q, carry_out_d;
  logic               overflow_q, overflow_d;
  logic               zero_q, zero_d;

  logic [31:0]        lsb;
  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK:0]     chunk_sum;
  logic [WIDTH-1:0]   merged;
  logic               last_chunk;

  // Chunk selection uses shifts so the slice position can follow the counter
  assign lsb        = 32'(cnt_q) * 32'(CHUNK);
  assign a_chunk    = CHUNK'(a_q >> lsb);
  assign b_chunk    = CHUNK'(b_q >> lsb);
  assign chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK+1)'(carry_q);
  assign merged     = (result_q & ~(CHUNK_MASK << lsb))
                    | (WIDTH'(chunk_sum[CHUNK-1:0]) << lsb);
  assign last_chunk = (cnt_q == CNT_W'(N - 1));

  // Next-state, datapath and flag computation
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    done_d      = 1'b0;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d = merged;
        carry_d  = chunk_sum[CHUNK];
        cnt_d    = cnt_q + 1'b1;
        if (last_chunk) begin
          state_d     = IDLE;
          done_d      = 1'b1;
          carry_out_d = chunk_sum[CHUNK];
          overflow_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (merged[WIDTH-1] != a_q[WIDTH-1]);
          zero_d      = (merged == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      done_q      <= done_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed bench for addsub_seq: default 6/2 instance for handshake and
// reset behaviour, plus a set of parameter variants checked against a model.
module tb_addsub_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, sub;
  logic [5:0] a, b;
  logic       busy, done, carry_out, overflow, zero;
  logic [5:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(6), .CHUNK(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  function automatic int wof(int g);
    return (g < 4) ? 6 : 16;
  endfunction

  function automatic int cof(int g);
    case (g)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return 6;
      4: return 1;
      5: return 4;
      default: return 16;
    endcase
  endfunction

  logic        s_start, s_sub;
  logic [15:0] s_a, s_b;
  logic [6:0]  sbusy, sdone, sc, sv, sz;
  logic [15:0] sres [7];

  for (genvar g = 0; g < 7; g++) begin : g_sw
    localparam int W = wof(g);
    localparam int C = cof(g);
    logic [W-1:0] r;
    addsub_seq #(.WIDTH(W), .CHUNK(C)) u (
      .clk(clk), .rst_n(rst_n), .start(s_start), .sub(s_sub),
      .a(s_a[W-1:0]), .b(s_b[W-1:0]),
      .busy(sbusy[g]), .done(sdone[g]), .result(r),
      .carry_out(sc[g]), .overflow(sv[g]), .zero(sz[g])
    );
    assign sres[g] = 16'(r);
  end

  // Reference: {result, carry, overflow, zero} for width w
  function automatic logic [18:0] model(int w, logic s, logic [15:0] x, logic [15:0] y);
    logic [16:0] m, aa, bb, sum;
    logic [15:0] r;
    logic        c, v;
    m   = (17'd1 << w) - 17'd1;
    aa  = {1'b0, x} & m;
    bb  = {1'b0, (s ? ~y : y)} & m;
    sum = aa + bb + {16'd0, s};
    r   = sum[15:0] & m[15:0];
    c   = sum[w];
    v   = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
    return {r, c, v, (r == 16'd0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic s, input logic [5:0] x, input logic [5:0] y, output int lat);
    start = 1'b1; sub = s; a = x; b = y;
    tick();
    start = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (done) break;
    end
  endtask

  task automatic op_check(input string tag, input logic s, input logic [5:0] x, input logic [5:0] y,
                          input logic [5:0] er, input logic [2:0] ecvz);
    int lat;
    do_op(s, x, y, lat);
    chk({tag, "_lat"}, lat, 3);
    chk({tag, "_res"}, result, er);
    chk({tag, "_cvz"}, {carry_out, overflow, zero}, ecvz);
  endtask

  initial begin
    int pulses, gap;
    int first [7];
    int cnt [7];
    logic [18:0] exp_v;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    s_start = 1'b0; s_sub = 1'b0; s_a = '0; s_b = '0;

    // Reset state
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_cvz", {carry_out, overflow, zero}, 0);
    rst_n = 1'b1;

    // Subtract without borrow, cycle by cycle
    start = 1'b1; sub = 1'b1; a = 6'd45; b = 6'd7;
    tick();
    start = 1'b0;
    chk("t1_e0_busy", busy, 1);
    chk("t1_e0_done", done, 0);
    tick();
    chk("t1_e1_busy", busy, 1);
    tick();
    chk("t1_e2_bd", {busy, done}, 2'b10);
    tick();
    chk("t1_e3_bd", {busy, done}, 2'b01);
    chk("t1_res", result, 6'd38);
    chk("t1_cvz", {carry_out, overflow, zero}, 3'b100);
    tick();
    chk("t1_e4_done", done, 0);
    chk("t1_hold", result, 6'd38);

    op_check("add45_7", 1'b0, 6'd45, 6'd7, 6'd52, 3'b000);
    op_check("add63_1", 1'b0, 6'd63, 6'd1, 6'd0, 3'b101);
    op_check("sub20_20", 1'b1, 6'd20, 6'd20, 6'd0, 3'b101);

    // Start held high and operands changed mid-operation
    start = 1'b1; sub = 1'b0; a = 6'd10; b = 6'd3;
    tick();
    sub = 1'b1; a = 6'd60; b = 6'd60;
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("hold_pulses", pulses, 1);
    chk("hold_done", done, 1);
    chk("hold_res", result, 6'd13);
    chk("hold_cvz", {carry_out, overflow, zero}, 3'b000);
    start = 1'b0;
    tick();
    chk("hold_after", {busy, done}, 2'b00);

    // Back-to-back: signed overflow add then borrowing subtract
    do_op(1'b0, 6'd31, 6'd1, gap);
    chk("b2b1_lat", gap, 3);
    chk("b2b1_res", result, 6'd32);
    chk("b2b1_cvz", {carry_out, overflow, zero}, 3'b010);
    start = 1'b1; sub = 1'b1; a = 6'd7; b = 6'd45;
    tick();
    start = 1'b0;
    chk("b2b_accept", {busy, done}, 2'b10);
    gap = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      gap++;
      if (done) break;
    end
    chk("b2b_gap", gap, 4);
    chk("b2b2_res", result, 6'd26);
    chk("b2b2_cvz", {carry_out, overflow, zero}, 3'b000);

    // Asynchronous reset one cycle into an operation
    start = 1'b1; sub = 1'b0; a = 6'd45; b = 6'd7;
    tick();
    start = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_bd", {busy, done}, 2'b00);
    chk("mrst_res", result, 6'd0);
    chk("mrst_cvz", {carry_out, overflow, zero}, 3'b000);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    chk("mrst_quiet", pulses, 0);
    op_check("mrst_after", 1'b1, 6'd45, 6'd7, 6'd38, 3'b100);

    // Parameter variants against the model
    for (int v = 0; v < 7; v++) begin
      if (v == 0) begin
        s_a = 16'hffff; s_b = 16'h0001; s_sub = 1'b0;
      end else begin
        s_a = 16'($urandom_range(0, 65535));
        s_b = 16'($urandom_range(0, 65535));
        s_sub = 1'($urandom_range(0, 1));
      end
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int g = 0; g < 7; g++) begin
        first[g] = 0;
        cnt[g] = 0;
      end
      for (int cyc = 1; cyc <= 20; cyc++) begin
        tick();
        for (int g = 0; g < 7; g++) begin
          if (sdone[g]) begin
            cnt[g]++;
            if (first[g] == 0) first[g] = cyc;
          end
        end
      end
      chk($sformatf("sw%0d_busy", v), sbusy, 0);
      for (int g = 0; g < 7; g++) begin
        exp_v = model(wof(g), s_sub, s_a, s_b);
        chk($sformatf("sw%0d_g%0d_lat", v, g), first[g], wof(g) / cof(g));
        chk($sformatf("sw%0d_g%0d_pulses", v, g), cnt[g], 1);
        chk($sformatf("sw%0d_g%0d_out", v, g), {sres[g], sc[g], sv[g], sz[g]}, exp_v);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
